// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: two requesters in the clk1 domain share one word-wide
// four-phase req/ack channel into the clk2 domain. A round-robin arbiter
// grants one requester from IDLE. The word is parked in hold registers and
// stays stable while req is high, so clk2 can sample it without a data
// synchronizer.
//
// Handshake (both requester ports): a word moves on a clk1 rising edge where
// reqN_valid and reqN_ready are both high. Ready is only ever high in IDLE,
// is a combinational response to valid, and at most one ready is high per
// cycle. A requester keeps valid/data stable until it sees ready. It may drop
// valid before its grant, and the word is then never transferred.
module cdc_xfer_arbiter #(
    parameter int DW = 8
) (
    input  logic          clk1,
    input  logic          clk2,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_id,
    output logic [1:0]    state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    // clk1 domain
    state_t        state_q, state_d;
    logic          req_q;
    logic          ack_meta_q;
    logic          ack_sync_q;
    logic          last_grant_q;
    logic [DW-1:0] hold_data_q;
    logic          hold_id_q;
    logic          grant_en;
    logic          grant_id;

    // clk2 domain
    logic          req_meta_q;
    logic          req_sync_q;
    logic          req_sync_dly_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_id_q;
    logic          req_rise;

    // Source FSM next state plus round-robin grant and combinational readies.
    always_comb begin
        state_d    = state_q;
        grant_en   = 1'b0;
        grant_id   = last_grant_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_en = 1'b1;
                    // On a tie the requester that did not win last time wins.
                    if (req0_valid && req1_valid) begin
                        grant_id = ~last_grant_q;
                    end else begin
                        grant_id = req1_valid;
                    end
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_sync_q) begin
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // clk1 state, req flop (decoded from next state so it is glitch-free), hold registers.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            last_grant_q <= 1'b1;
            hold_data_q  <= '0;
            hold_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == REQ_HI);
            if (grant_en) begin
                last_grant_q <= grant_id;
                hold_id_q    <= grant_id;
                hold_data_q  <= grant_id ? req1_data : req0_data;
            end
        end
    end

    // Two-flop synchronizer bringing the clk2-side ack (req_sync) back into clk1.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= req_sync_q;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign req_rise = req_sync_q & ~req_sync_dly_q;

    // clk2 req synchronizer, edge detect and output capture of the held word.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            req_meta_q     <= 1'b0;
            req_sync_q     <= 1'b0;
            req_sync_dly_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_id_q       <= 1'b0;
        end else begin
            req_meta_q     <= req_q;
            req_sync_q     <= req_meta_q;
            req_sync_dly_q <= req_sync_q;
            out_valid_q    <= req_rise;
            if (req_rise) begin
                out_data_q <= hold_data_q;
                out_id_q   <= hold_id_q;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter. A round-robin reference model predicts grants
// in clk1, and a queue of expected (id,data) words is checked against every
// out_valid pulse in clk2.
`timescale 1ns/1ps
module tb_cdc_xfer_arbiter;
  localparam int DW = 8;

  // clock / reset
  logic clk1, clk2, reset;
  realtime half1 = 5.0;
  realtime half2 = 6.5;

  initial begin
    clk1 = 1'b0;
    forever #(half1) clk1 = ~clk1;
  end

  initial begin
    clk2 = 1'b0;
    forever #(half2) clk2 = ~clk2;
  end

  // DUT
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          busy, out_valid, out_id;
  logic [DW-1:0] out_data;
  logic [1:0]    state_dbg;

  cdc_xfer_arbiter #(.DW(DW)) dut (
    .clk1        (clk1),
    .clk2        (clk2),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .state_dbg_o (state_dbg)
  );

  // bench state
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   obs_q[$];
  bit  acc0, acc1;
  bit  gap_en;
  int  pulse1;
  logic m_last;
  int  r0_cnt = 0;
  int  r1_cnt = 0;
  int  out_cnt = 0;

  // driver tasks
  task automatic driver();
    forever begin
      @(posedge clk1);
      #1;
      if (!reset) begin
        if (acc0) begin
          void'(q0.pop_front());
          req0_valid = 1'b0;
          acc0 = 1'b0;
        end
        if (acc1) begin
          void'(q1.pop_front());
          req1_valid = 1'b0;
          acc1 = 1'b0;
        end
        if (!req0_valid && q0.size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
          req0_valid = 1'b1;
          req0_data  = q0[0];
        end
        if (pulse1 == 1) begin
          req1_valid = 1'b1;
          req1_data  = 8'hEE;
          pulse1 = 2;
        end else if (pulse1 == 2) begin
          req1_valid = 1'b0;
          pulse1 = 0;
        end else if (!req1_valid && q1.size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
          req1_valid = 1'b1;
          req1_data  = q1[0];
        end
      end
    end
  endtask

  // Reference model: whenever the source is idle and someone is valid, exactly
  // one requester is granted, alternating on ties.
  task automatic mon_clk1();
    logic g, e0, e1, prev_req, grant_prev, prev_hid;
    logic [DW-1:0] prev_hd;
    prev_req = 1'b0;
    grant_prev = 1'b0;
    prev_hid = 1'b0;
    prev_hd = '0;
    forever begin
      @(negedge clk1);
      if (reset) begin
        prev_req = 1'b0;
        grant_prev = 1'b0;
      end else begin
        e0 = 1'b0;
        e1 = 1'b0;
        g  = 1'b0;
        if (!busy && (req0_valid || req1_valid)) begin
          g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
          e0 = ~g;
          e1 = g;
        end
        vectors++;
        if ({req1_ready, req0_ready} !== {e1, e0}) begin
          miscompares++;
          $display("FAIL ready: got r1r0=%b%b want %b%b at %0t", req1_ready, req0_ready, e1, e0, $time);
        end
        if (req0_ready === 1'b1) r0_cnt++;
        if (req1_ready === 1'b1) r1_cnt++;
        if (grant_prev) begin
          vectors++;
          if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_grant: got %b want 1 at %0t", busy, $time);
          end
        end
        if (e0 || e1) begin
          m_last = g;
          exp_q.push_back(g ? {1'b1, req1_data} : {1'b0, req0_data});
          acc0 = e0;
          acc1 = e1;
        end
        grant_prev = e0 | e1;
        vectors++;
        if (busy !== (state_dbg != 2'd0)) begin
          miscompares++;
          $display("FAIL busy_state: got busy=%b state=%0d at %0t", busy, state_dbg, $time);
        end
        if (prev_req && dut.req_q) begin
          vectors++;
          if ({dut.hold_id_q, dut.hold_data_q} !== {prev_hid, prev_hd}) begin
            miscompares++;
            $display("FAIL hold_stable: got %h want %h at %0t", {dut.hold_id_q, dut.hold_data_q}, {prev_hid, prev_hd}, $time);
          end
        end
        prev_req = dut.req_q;
        prev_hid = dut.hold_id_q;
        prev_hd  = dut.hold_data_q;
      end
    end
  endtask

  // scoreboard: every out_valid pops one expected word
  task automatic mon_clk2();
    logic prev_ov;
    logic [DW:0] last, e;
    prev_ov = 1'b0;
    last = '0;
    forever begin
      @(negedge clk2);
      if (reset) begin
        prev_ov = 1'b0;
        last = '0;
      end else begin
        vectors++;
        if (out_valid === 1'b1) begin
          if (prev_ov) begin
            miscompares++;
            $display("FAIL out_valid_double: got 2 consecutive pulses want 1 at %0t", $time);
          end
          obs_q.push_back({out_id, out_data});
          out_cnt++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got id=%b data=%h want no pulse at %0t", out_id, out_data, $time);
          end else begin
            e = exp_q.pop_front();
            if ({out_id, out_data} !== e) begin
              miscompares++;
              $display("FAIL out_word: got %h want %h at %0t", {out_id, out_data}, e, $time);
            end
          end
          last = {out_id, out_data};
        end else if ({out_id, out_data} !== last) begin
          miscompares++;
          $display("FAIL out_hold: got %h want %h at %0t", {out_id, out_data}, last, $time);
        end
        prev_ov = (out_valid === 1'b1);
      end
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    exp_q.delete();
    obs_q.delete();
    acc0 = 1'b0;
    acc1 = 1'b0;
    pulse1 = 0;
    gap_en = 1'b0;
    m_last = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk1);
    #3 reset = 1'b0;
    repeat (4) @(posedge clk1);
    repeat (4) @(posedge clk2);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_model();
    release_reset();
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk1);
      if (q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
          pulse1 == 0 && exp_q.size() == 0 && busy === 1'b0)
        done = 1'b1;
    end
    repeat (3) @(negedge clk2);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: got pending exp=%0d q0=%0d q1=%0d busy=%b want all idle", exp_q.size(), q0.size(), q1.size(), busy);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({busy, req0_ready, req1_ready, out_valid, out_id, out_data, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL %s: got busy=%b rdy=%b%b ov=%b id=%b data=%h st=%0d want all 0", tag,
               busy, req1_ready, req0_ready, out_valid, out_id, out_data, state_dbg);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    clear_model();
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_asserted");
    release_reset();
    check_outputs_zero("reset_released");
  endtask

  task automatic test_single_word();
    int r0b;
    apply_reset();
    r0b = r0_cnt;
    q0.push_back(8'hA5);
    wait_drain(2000);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h0A5) begin
      miscompares++;
      $display("FAIL single_word: got n=%0d first=%h want 1 word 0a5", obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 9'h1FF);
    end
    vectors++;
    if (r0_cnt - r0b != 1) begin
      miscompares++;
      $display("FAIL single_ready: got %0d ready cycles want 1", r0_cnt - r0b);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [DW:0] want[4];
    want[0] = 9'h011;
    want[1] = 9'h133;
    want[2] = 9'h022;
    want[3] = 9'h144;
    apply_reset();
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    q1.push_back(8'h33);
    q1.push_back(8'h44);
    wait_drain(4000);
    vectors++;
    if (obs_q.size() != 4) begin
      miscompares++;
      $display("FAIL rr_count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== want[i]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit hit;
    int oc;
    apply_reset();
    q0.push_back(8'h77);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk1);
      if (state_dbg == 2'd1) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL mid_reach_req_hi: got state=%0d want 1", state_dbg);
    end
    reset = 1'b1;
    clear_model();
    #1 check_outputs_zero("mid_reset_outputs");
    oc = out_cnt;
    release_reset();
    repeat (20) @(negedge clk1);
    vectors++;
    if (out_cnt != oc) begin
      miscompares++;
      $display("FAIL mid_aborted_word: got %0d pulses want 0", out_cnt - oc);
    end
    q0.push_back(8'h5A);
    wait_drain(2000);
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h05A) begin
      miscompares++;
      $display("FAIL mid_next_word: got n=%0d first=%h want 1 word 05a", obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 9'h1FF);
    end
  endtask

  task automatic test_drop_valid();
    int r1b;
    bit hit;
    apply_reset();
    r1b = r1_cnt;
    q0.push_back(8'h3C);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk1);
      if (busy === 1'b1) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL drop_busy: got %b want 1", busy);
    end
    pulse1 = 1;
    wait_drain(2000);
    vectors++;
    if (r1_cnt != r1b) begin
      miscompares++;
      $display("FAIL drop_ready1: got %0d ready cycles want 0", r1_cnt - r1b);
    end
    vectors++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h03C) begin
      miscompares++;
      $display("FAIL drop_words: got n=%0d first=%h want 1 word 03c", obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 9'h1FF);
    end
  endtask

  task automatic test_random_ratio(input realtime h1, input realtime h2);
    int oc, rc;
    reset = 1'b1;
    half1 = h1;
    half2 = h2;
    clear_model();
    release_reset();
    gap_en = 1'b1;
    oc = out_cnt;
    rc = r0_cnt + r1_cnt;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(DW'($urandom));
      else q1.push_back(DW'($urandom));
    end
    wait_drain(20000);
    vectors++;
    if (out_cnt - oc != 100) begin
      miscompares++;
      $display("FAIL random_out_count: got %0d want 100 (h1=%0t h2=%0t)", out_cnt - oc, h1, h2);
    end
    vectors++;
    if (r0_cnt + r1_cnt - rc != 100) begin
      miscompares++;
      $display("FAIL random_accept_count: got %0d want 100", r0_cnt + r1_cnt - rc);
    end
  endtask

  // main sequence and final report
  initial begin
    reset = 1'b0;
    clear_model();
    fork
      driver();
      mon_clk1();
      mon_clk2();
    join_none
    test_reset();
    test_single_word();
    test_round_robin();
    test_reset_mid_transfer();
    test_drop_valid();
    test_random_ratio(20.0, 5.0);
    test_random_ratio(5.0, 20.0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameter DW, default 8, width of the data word carried across the clock boundary.
REQ-002 clk1  input  1  source-domain clock; the arbiter and source FSM run on its rising edge.
REQ-003 clk2  input  1  destination-domain clock, asynchronous to clk1.
REQ-004 reset  input  1  asynchronous, active-high; clears both domains.
REQ-005 req0_valid  input  1  clk1 domain; requester 0 has a word to send.
REQ-006 req0_data  input  DW  clk1 domain; requester 0 word, sampled when req0_valid and req0_ready are both high.
REQ-007 req0_ready  output  1  clk1 domain; requester 0 word accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready  as REQ-005..007, for requester 1.
REQ-009 busy  output  1  clk1 domain; high whenever the source FSM is not IDLE.
REQ-010 out_valid  output  1  clk2 domain; one-cycle pulse, new word present.
REQ-011 out_data  output  DW  clk2 domain; transferred word, held until the next out_valid.
REQ-012 out_id  output  1  clk2 domain; requester index of out_data.

Function
REQ-013 The block SHALL move one word at a time from clk1 to clk2 using a four-phase req/ack handshake; data and id SHALL be held in clk1 registers (hold_data, hold_id) stable while req is high.
REQ-014 Source FSM states SHALL be IDLE, REQ_HI and REQ_LO.
REQ-015 IDLE: if any reqN_valid is high, grant exactly one requester; assert its reqN_ready combinationally in that cycle; load hold_data/hold_id; go to REQ_HI; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; if one is valid, grant it; update last_grant on every grant.
REQ-017 REQ_HI: req register = 1; on ack_sync = 1 go to REQ_LO.
REQ-018 REQ_LO: req register = 0; on ack_sync = 0 go to IDLE.
REQ-019 reqN_ready SHALL be low in REQ_HI and REQ_LO; only one ready SHALL be high in any cycle.
REQ-020 req SHALL be a clk1 flop (glitch-free) and SHALL reach clk2 through a two-flop synchronizer (req_meta, req_sync) followed by an edge register req_sync_d.
REQ-021 On a clk2 edge where req_sync = 1 and req_sync_d = 0, out_data <= hold_data, out_id <= hold_id and out_valid <= 1; otherwise out_valid <= 0.
REQ-022 The ack returned to clk1 SHALL be req_sync; clk1 SHALL synchronize it through two flops into ack_sync.
REQ-023 Latency: out_valid SHALL rise on the 3rd clk2 rising edge after req rises; the next grant SHALL occur no sooner than the first IDLE cycle after ack_sync falls.
REQ-024 Exactly one out_valid pulse SHALL occur per accepted word; no word SHALL be dropped or duplicated.
REQ-025 Requesters SHALL keep reqN_valid and reqN_data stable until their ready is seen; dropping valid before the grant SHALL be legal and SHALL cause no transfer.

Reset
REQ-026 While reset is high: state = IDLE, req = 0, ack_sync = 0, last_grant = 1 (requester 0 wins the first tie), hold_data = 0, hold_id = 0, req_meta = req_sync = req_sync_d = 0, out_valid = 0, out_data = 0, out_id = 0, busy = 0, reqN_ready = 0.
REQ-027 Reset asserted mid-transfer SHALL abort it; after release, no out_valid SHALL occur for the aborted word.
REQ-028 Reset deassertion need not be synchronous to either clock; the bench SHALL release it with at least 3 idle cycles in each domain before stimulus.

Verification
REQ-029 clk1 10 ns, clk2 13 ns; req0 sends 0xA5 -> req0_ready pulses 1 cycle; out_valid 1 pulse with out_data=0xA5, out_id=0; busy returns to 0.
REQ-030 Both valid continuously; req0 sends 0x11,0x22, req1 sends 0x33,0x44 -> out sequence (id,data) = (0,11),(1,33),(0,22),(1,44).
REQ-031 clk2 = 4x clk1 and clk2 = 1/4 clk1, 100 random words each -> scoreboard exact match, one out_valid per word.
REQ-032 Reset asserted while state = REQ_HI -> all outputs 0; no out_valid after release; the next word 0x5A transfers correctly.
REQ-033 req1_valid pulsed for 1 cycle while busy, then dropped -> no transfer for req1 and req1_ready never high.
REQ-034 Assertions: hold_data/hold_id stable while req = 1; reqN_ready mutually exclusive; out_valid never high on 2 consecutive clk2 cycles.
